// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the pipelined ALU slice.
//   op_e    : 3-bit operation encoding carried on the Op port.
//   flags_t : bundle of the zero / greater / less / not-zero result flags.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_ROR = 3'b001,
        OP_ROL = 3'b010,
        OP_SLL = 3'b011,
        OP_SRL = 3'b100,
        OP_SRA = 3'b101,
        OP_AND = 3'b110,
        OP_XOR = 3'b111
    } op_e;

    typedef struct packed {
        logic zf;
        logic gzf;
        logic lzf;
        logic nezf;
    } flags_t;

    // Reset image of the flag register: zf set, everything else clear.
    localparam flags_t FLAGS_RESET = flags_t'(4'b1000);

    // Flags of a result read as a signed number.
    function automatic flags_t flags_of(input logic is_zero, input logic msb);
        flags_t f;
        f.zf   = is_zero;
        f.nezf = ~is_zero;
        f.lzf  = msb;
        f.gzf  = ~is_zero & ~msb;
        return f;
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core
//   Purely combinational ALU datapath; operands arrive already inverted.
//   a, b   : decoded operands (WIDTH bits)
//   cin    : carry-in for ADD
//   op     : operation select
//   sign   : selects signed (1) or unsigned (0) overflow for ADD
//   out    : result
//   ofl    : overflow (ADD only, 0 otherwise)
//   flags  : zero / greater / less / not-zero flags of out
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  op_e              op,
    input  logic             sign,
    output logic [WIDTH-1:0] out,
    output logic             ofl,
    output flags_t           flags
);

    logic [WIDTH:0]          sum;
    logic [SHW-1:0]          sh;
    logic [WIDTH-1:0]        ror_v;
    logic [WIDTH-1:0]        rol_v;
    logic signed [WIDTH-1:0] sra_v;

    assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sh  = b[SHW-1:0];

    // A shift by WIDTH yields zero, so sh==0 collapses each rotate to a.
    assign ror_v = (a >> sh) | (a << (WIDTH - int'(sh)));
    assign rol_v = (a << sh) | (a >> (WIDTH - int'(sh)));
    assign sra_v = $signed(a) >>> sh;

    always_comb begin
        out = '0;
        ofl = 1'b0;
        unique case (op)
            OP_ADD: begin
                out = sum[WIDTH-1:0];
                if (sign)
                    ofl = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                else
                    ofl = sum[WIDTH];
            end
            OP_ROR: out = ror_v;
            OP_ROL: out = rol_v;
            OP_SLL: out = a << sh;
            OP_SRL: out = a >> sh;
            OP_SRA: out = sra_v;
            OP_AND: out = a & b;
            OP_XOR: out = a ^ b;
            default: out = '0;
        endcase
    end

    assign flags = flags_of(out == '0, out[WIDTH-1]);

endmodule

// File: rtl/alu_pipelined.sv
// alu_pipelined
//   Two-stage valid/ready pipelined ALU.
//   S1 holds decoded operands and op; S2 holds the result, overflow and flags.
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     in_valid / in_ready : input handshake
//     A, B, Cin, Op       : operands, carry-in, operation
//     invA, invB          : invert operand before use
//     sign                : signed overflow selection for ADD
//     flush               : drop everything in flight on the next edge
//     out_valid/out_ready : output handshake
//     Out, Ofl            : result and overflow
//     zf, gzf, lzf, nezf  : result flags (signed view of Out)
module alu_pipelined
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [2:0]       Op,
    input  logic             invA,
    input  logic             invB,
    input  logic             sign,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             Ofl,
    output logic             zf,
    output logic             gzf,
    output logic             lzf,
    output logic             nezf
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_cin;
    op_e              s1_op;
    logic             s1_sign;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_out;
    logic             s2_ofl;
    flags_t           s2_flags;

    logic [WIDTH-1:0] core_out;
    logic             core_ofl;
    flags_t           core_flags;

    logic s1_adv;
    logic s2_adv;
    logic s1_load;
    logic s2_load;

    // Ready propagates backwards combinationally so a full pipeline can
    // accept and emit on the same edge without a bubble.
    assign s2_adv   = ~s2_valid | out_ready;
    assign s1_adv   = ~s1_valid | s2_adv;
    assign in_ready = s1_adv & ~flush;
    assign s1_load  = in_valid & in_ready;
    assign s2_load  = s1_valid & s2_adv & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            s1_valid <= 1'b0;
        else if (flush)
            s1_valid <= 1'b0;
        else if (s1_adv)
            s1_valid <= s1_load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_a    <= '0;
            s1_b    <= '0;
            s1_cin  <= 1'b0;
            s1_op   <= OP_ADD;
            s1_sign <= 1'b0;
        end else if (s1_load) begin
            s1_a    <= invA ? ~A : A;
            s1_b    <= invB ? ~B : B;
            s1_cin  <= Cin;
            s1_op   <= op_e'(Op);
            s1_sign <= sign;
        end
    end

    alu_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .a     (s1_a),
        .b     (s1_b),
        .cin   (s1_cin),
        .op    (s1_op),
        .sign  (s1_sign),
        .out   (core_out),
        .ofl   (core_ofl),
        .flags (core_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            s2_valid <= 1'b0;
        else if (flush)
            s2_valid <= 1'b0;
        else if (s2_adv)
            s2_valid <= s1_valid;
    end

    // Result registers move only on a real transfer, so a stalled or
    // drained stage keeps presenting its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_out   <= '0;
            s2_ofl   <= 1'b0;
            s2_flags <= FLAGS_RESET;
        end else if (s2_load) begin
            s2_out   <= core_out;
            s2_ofl   <= core_ofl;
            s2_flags <= core_flags;
        end
    end

    assign out_valid = s2_valid;
    assign Out       = s2_out;
    assign Ofl       = s2_ofl;
    assign zf        = s2_flags.zf;
    assign gzf       = s2_flags.gzf;
    assign lzf       = s2_flags.lzf;
    assign nezf      = s2_flags.nezf;

endmodule

// File: tb/tb_alu_pipelined.sv
// tb_alu_pipelined
//   Randomized and directed bench for alu_pipelined (WIDTH=16 and WIDTH=32).
//   A negedge monitor predicts every accepted operation with an arithmetic
//   reference model and compares results in acceptance order.
module tb_alu_pipelined;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, flush;
    logic [W-1:0] A, B, Out;
    logic         Cin, invA, invB, sign, Ofl, zf, gzf, lzf, nezf;
    logic [2:0]   Op;

    logic         in_valid_w, in_ready_w, out_valid_w;
    logic [31:0]  a_w, b_w, out_w;
    logic         ofl_w, zf_w, gzf_w, lzf_w, nezf_w;

    alu_pipelined #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .Op(Op), .invA(invA), .invB(invB),
        .sign(sign), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .Out(Out), .Ofl(Ofl), .zf(zf), .gzf(gzf), .lzf(lzf), .nezf(nezf)
    );

    alu_pipelined #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .A(a_w), .B(b_w), .Cin(1'b1), .Op(3'b000), .invA(1'b0), .invB(1'b1),
        .sign(1'b1), .flush(1'b0), .out_valid(out_valid_w), .out_ready(1'b1),
        .Out(out_w), .Ofl(ofl_w), .zf(zf_w), .gzf(gzf_w), .lzf(lzf_w), .nezf(nezf_w)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [W-1:0] out;
        logic         ofl;
        logic         zf, gzf, lzf, nezf;
    } exp_t;

    exp_t q[$];

    // Reference: operands as integers, shifts as powers of two, rotates
    // one bit at a time, overflow as range violation of the exact sum.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic [2:0] op,
                                   input logic ia, input logic ib, input logic sg);
        exp_t r;
        logic [W-1:0] x, y, v;
        longint m, ux, uy, sx, sy, c, s, p, sv;
        int n;
        m  = longint'(1) << W;
        x  = ia ? ~a : a;
        y  = ib ? ~b : b;
        ux = longint'(x);
        uy = longint'(y);
        sx = x[W-1] ? ux - m : ux;
        sy = y[W-1] ? uy - m : uy;
        c  = longint'(cin);
        n  = int'(uy % W);
        p  = 1;
        repeat (n) p = p * 2;
        r.ofl = 1'b0;
        v = '0;
        case (op)
            3'd0: begin
                s = ux + uy + c;
                v = W'(s % m);
                if (sg) r.ofl = ((sx + sy + c) >= m / 2) || ((sx + sy + c) < -(m / 2));
                else    r.ofl = (s >= m);
            end
            3'd1: begin v = x; repeat (n) v = {v[0], v[W-1:1]}; end
            3'd2: begin v = x; repeat (n) v = {v[W-2:0], v[W-1]}; end
            3'd3: v = W'((ux * p) % m);
            3'd4: v = W'(ux / p);
            3'd5: begin
                s = sx / p;
                if (sx < 0 && (sx % p) != 0) s = s - 1;
                if (s < 0) s = s + m;
                v = W'(s);
            end
            3'd6: v = x & y;
            default: v = x ^ y;
        endcase
        r.out  = v;
        sv     = v[W-1] ? longint'(v) - m : longint'(v);
        r.zf   = (sv == 0);
        r.lzf  = (sv < 0);
        r.gzf  = (sv > 0);
        r.nezf = (sv != 0);
        return r;
    endfunction

    // Monitor: decides transfers just before each rising edge.
    logic stalled = 1'b0;
    logic [W+4:0] held;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("hold_valid", out_valid, 1'b1);
                    check("hold_outputs", {Out, Ofl, zf, gzf, lzf, nezf}, held);
                end
                check("in_ready", in_ready, !flush && !(q.size() == 2 && !out_ready));
                if (flush) begin
                    q.delete();
                    stalled = 1'b0;
                end else begin
                    if (out_valid && out_ready) begin
                        if (q.size() == 0) begin
                            check("spurious_out", out_valid, 1'b0);
                        end else begin
                            e = q.pop_front();
                            check("out", Out, e.out);
                            check("ofl", Ofl, e.ofl);
                            check("flags", {zf, gzf, lzf, nezf}, {e.zf, e.gzf, e.lzf, e.nezf});
                        end
                    end
                    stalled = out_valid && !out_ready;
                    held    = {Out, Ofl, zf, gzf, lzf, nezf};
                    if (in_valid && in_ready)
                        q.push_back(model(A, B, Cin, Op, invA, invB, sign));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs(input logic [2:0] op);
        A    = W'($urandom);
        B    = W'($urandom);
        Cin  = 1'($urandom);
        Op   = op;
        invA = 1'($urandom);
        invB = 1'($urandom);
        sign = 1'($urandom);
    endtask

    task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic [2:0] op, input logic ia,
                           input logic ib, input logic sg, input logic [W-1:0] eo,
                           input logic eofl, input logic [3:0] ef);
        out_ready = 1'b1;
        A = a; B = b; Cin = cin; Op = op; invA = ia; invB = ib; sign = sg;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_lat1"}, out_valid, 1'b0);
        tick();
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_out"}, Out, eo);
        check({tag, "_ofl"}, Ofl, eofl);
        check({tag, "_flags"}, {zf, gzf, lzf, nezf}, ef);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pat[4] = '{1, 0, 0, 1};
        int sent;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        A = '0; B = '0; Cin = 1'b0; Op = 3'd0; invA = 1'b0; invB = 1'b0; sign = 1'b0;
        in_valid_w = 1'b0; a_w = '0; b_w = '0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out", Out, 16'h0000);
        check("rst_ofl", Ofl, 1'b0);
        check("rst_flags", {zf, gzf, lzf, nezf}, 4'b1000);
        check("rst_w_flags", {out_valid_w, zf_w, nezf_w}, 3'b010);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        tick();
        check("ready_after_rst", in_ready, 1'b1);

        // Directed values
        run_one("add_neg",  16'h0005, 16'h000A, 1, 3'd0, 0, 1, 1, 16'hFFFB, 0, 4'b0011);
        run_one("ror4",     16'hA00A, 16'h0004, 0, 3'd1, 0, 0, 0, 16'hAA00, 0, 4'b0011);
        run_one("ror8",     16'h8ABD, 16'h0008, 0, 3'd1, 0, 0, 0, 16'hBD8A, 0, 4'b0011);
        run_one("rol1",     16'h8001, 16'h0001, 0, 3'd2, 0, 0, 0, 16'h0003, 0, 4'b0101);
        run_one("sra15",    16'h8000, 16'h000F, 0, 3'd5, 0, 0, 0, 16'hFFFF, 0, 4'b0011);
        run_one("ror0",     16'h1234, 16'h0010, 0, 3'd1, 0, 0, 0, 16'h1234, 0, 4'b0101);
        run_one("add_sovf", 16'h7FFF, 16'h0001, 0, 3'd0, 0, 0, 1, 16'h8000, 1, 4'b0011);
        run_one("add_uovf", 16'hFFFF, 16'h0001, 0, 3'd0, 0, 0, 0, 16'h0000, 1, 4'b1000);
        tick();

        // Eight back-to-back ADDs with out_ready cycling 1,0,0,1
        sent = 0;
        for (int cyc = 0; cyc < 100 && sent < 8; cyc++) begin
            out_ready = pat[cyc % 4][0];
            in_valid  = 1'b1;
            rand_inputs(3'd0);
            @(negedge clk);
            if (in_ready) sent++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        check("stream_sent", sent, 8);
        check("stream_drained", q.size(), 0);

        // Flush with two operations in flight
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_inputs(3'd0); tick();
        rand_inputs(3'd6); tick();
        flush = 1'b1;
        rand_inputs(3'd7); tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_queue", q.size(), 0);
        repeat (3) begin
            out_ready = 1'b1;
            tick();
            check("flush_no_emit", out_valid, 1'b0);
        end
        run_one("post_flush", 16'h00F0, 16'h0FF0, 0, 3'd7, 0, 0, 0, 16'h0F00, 0, 4'b0101);
        tick();

        // Random traffic, interrupted by an asynchronous reset
        for (int i = 0; i < 200; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 40) == 0;
            rand_inputs(3'($urandom));
            tick();
        end
        flush = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        repeat (3) begin rand_inputs(3'($urandom)); tick(); end
        check("pre_rst_valid", out_valid, 1'b1);
        #2 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_out", Out, 16'h0000);
        check("mid_rst_flags", {Ofl, zf, gzf, lzf, nezf}, 5'b01000);
        @(posedge clk);
        #3 rst = 1'b0;
        tick();
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 50) == 0;
            rand_inputs(3'($urandom));
            tick();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        check("random_drained", q.size(), 0);

        // 32-bit instance: same signed ADD with extended operands
        check("w_ready", in_ready_w, 1'b1);
        a_w = 32'h0000_0005;
        b_w = 32'h0000_000A;
        in_valid_w = 1'b1;
        tick();
        in_valid_w = 1'b0;
        check("w_lat1", out_valid_w, 1'b0);
        tick();
        check("w_valid", out_valid_w, 1'b1);
        check("w_out", out_w, 32'hFFFF_FFFB);
        check("w_ofl", ofl_w, 1'b0);
        check("w_flags", {zf_w, gzf_w, lzf_w, nezf_w}, 4'b0011);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
